// File: rtl/midi_msg_encoder_pkg.sv
// Shared MIDI encoder definitions: event codes, status nibbles, FSM states.
// Used by midi_msg_encoder and its handshake interface.
package midi_msg_encoder_pkg;

  localparam logic [1:0] EV_NOTE_OFF  = 2'b00;
  localparam logic [1:0] EV_NOTE_ON   = 2'b01;
  localparam logic [1:0] EV_KEYPRESS  = 2'b10;
  localparam logic [1:0] EV_PITCH     = 2'b11;

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [3:0] NIB_KEYPRESS = 4'hA;
  localparam logic [3:0] NIB_PITCH    = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STATUS,
    ST_DATA1,
    ST_DATA2
  } state_e;

  function automatic logic [3:0] status_nib(
    input logic [1:0] t,
    input bit         off_as_on
  );
    logic [3:0] nib;
    nib = NIB_NOTE_OFF;
    unique case (1'b1)
      t == EV_NOTE_OFF:
        nib = off_as_on ? NIB_NOTE_ON : NIB_NOTE_OFF;
      t == EV_NOTE_ON:  nib = NIB_NOTE_ON;
      t == EV_KEYPRESS: nib = NIB_KEYPRESS;
      t == EV_PITCH:    nib = NIB_PITCH;
      default:          nib = NIB_NOTE_OFF;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/midi_msg_encoder_if.sv
// Event-in / byte-out handshake bundle for the MIDI message encoder.
// slave = encoder side, master = producer of events and consumer of bytes.
interface midi_msg_encoder_if;

  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_type;
  logic [3:0] channel;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  modport slave (
    input  ev_valid,
    input  ev_type,
    input  channel,
    input  note,
    input  velocity,
    input  tx_ready,
    output ev_ready,
    output tx_data,
    output tx_valid,
    output busy
  );

  modport master (
    output ev_valid,
    output ev_type,
    output channel,
    output note,
    output velocity,
    output tx_ready,
    input  ev_ready,
    input  tx_data,
    input  tx_valid,
    input  busy
  );

endinterface

// File: rtl/midi_msg_encoder.sv
// Serialises one note/controller event into status, data1, data2 bytes.
// Define MIDI_RUNNING_STATUS_EN to drop repeated status bytes.
import midi_msg_encoder_pkg::*;

module midi_msg_encoder #(
`ifdef MIDI_RUNNING_STATUS_EN
  parameter int RS_TIMEOUT      = 9600000,
  parameter int RS_CNT_W        = 24,
`endif
  parameter bit NOTE_OFF_AS_ON0 = 1'b1
) (
  input  logic                clk96,
  input  logic                rst_n,
  midi_msg_encoder_if.slave   bus
);

  state_e     state;
  logic [7:0] tx_data_q;
  logic [6:0] d1_q;
  logic [6:0] d2_q;
  logic [7:0] st_byte;
  logic [6:0] d2_in;
  logic       accept;
  logic       skip_st;

  assign bus.ev_ready = (state == ST_IDLE) && rst_n;
  assign bus.tx_valid = (state != ST_IDLE);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.tx_data  = tx_data_q;

  assign accept  = bus.ev_valid && bus.ev_ready;
  assign st_byte = {status_nib(bus.ev_type, NOTE_OFF_AS_ON0),
                    bus.channel};

  // note-off sent as note-on must carry zero velocity
  assign d2_in = (NOTE_OFF_AS_ON0 && bus.ev_type == EV_NOTE_OFF)
               ? 7'd0 : bus.velocity;

`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic [RS_CNT_W-1:0] RS_TO = RS_CNT_W'(RS_TIMEOUT);

  logic [7:0]          last_q;
  logic                last_vld;
  logic [RS_CNT_W-1:0] idle_cnt;

  assign skip_st = last_vld && (idle_cnt < RS_TO)
                && (last_q == st_byte);

  always_ff @(posedge clk96) begin
    if (!rst_n) begin
      last_q   <= 8'h00;
      last_vld <= 1'b0;
      idle_cnt <= '0;
    end else if (accept) begin
      idle_cnt <= '0;
      if (!skip_st) begin
        last_q   <= st_byte;
        last_vld <= 1'b1;
      end
    end else if (state == ST_IDLE) begin
      if (idle_cnt < RS_TO) idle_cnt <= idle_cnt + 1'b1;
      else                  last_vld <= 1'b0;
    end
  end
`else
  assign skip_st = 1'b0;
`endif

  always_ff @(posedge clk96) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_data_q <= 8'h00;
      d1_q      <= 7'd0;
      d2_q      <= 7'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            d1_q <= bus.note;
            d2_q <= d2_in;
            if (skip_st) begin
              state     <= ST_DATA1;
              tx_data_q <= {1'b0, bus.note};
            end else begin
              state     <= ST_STATUS;
              tx_data_q <= st_byte;
            end
          end
        end
        ST_STATUS: begin
          if (bus.tx_ready) begin
            state     <= ST_DATA1;
            tx_data_q <= {1'b0, d1_q};
          end
        end
        ST_DATA1: begin
          if (bus.tx_ready) begin
            state     <= ST_DATA2;
            tx_data_q <= {1'b0, d2_q};
          end
        end
        ST_DATA2: begin
          if (bus.tx_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
